// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display scheduler.
// Holds the arbitration state enum, the display word width and an index-width helper.
package disp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        HOLD
    } state_t;

    localparam int DISP_DATA_W = 32;

    function automatic int src_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_scan_prescaler.sv
// Free-running divider that produces the one-cycle digit-scan clock enable.
// The counter runs 0..SCAN_DIV-1 and scan_ce is high while it sits at SCAN_DIV-1.
module disp_scan_prescaler #(
    parameter int SCAN_DIV = 100000
) (
    input  logic system_clock,
    input  logic cpu_rst_n,
    output logic scan_ce
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge system_clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign scan_ce = (cnt == CNT_LAST);

endmodule

// File: rtl/display_scheduler.sv
// Round-robin owner arbitration of the 8-digit display with a minimum dwell in scan periods.
// Build option: define DISP_SRC_TAG_EN to show the owner index in the leftmost digit (seg87[7:4]).
module display_scheduler
    import disp_sched_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int SCAN_DIV    = 100000,
    parameter int DWELL_SCANS = 4000
) (
    input  logic                               system_clock,
    input  logic                               cpu_rst_n,
    input  logic [NUM_SRC-1:0]                 src_req,
    input  logic [NUM_SRC*DISP_DATA_W-1:0]     src_data,
    output logic [NUM_SRC-1:0]                 src_grant,
    output logic [src_idx_w(NUM_SRC)-1:0]      active_src,
    output logic                               display_valid,
    output logic                               scan_ce,
    output logic [7:0]                         seg87,
    output logic [7:0]                         seg65,
    output logic [7:0]                         seg43,
    output logic [7:0]                         seg21
);

    localparam int SRC_W = src_idx_w(NUM_SRC);
    localparam int DW_W  = $clog2(DWELL_SCANS + 1);
    localparam logic [DW_W-1:0]  DW_MAX   = DW_W'(DWELL_SCANS);
    localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NUM_SRC - 1);

    state_t                  state_q, state_d;
    logic [NUM_SRC-1:0]      grant_q, grant_d;
    logic [SRC_W-1:0]        active_q, active_d;
    logic                    valid_q, valid_d;
    logic [DISP_DATA_W-1:0]  seg_q, seg_d;
    logic [DW_W-1:0]         dwell_q, dwell_d;
    logic [SRC_W-1:0]        rr_q, rr_d;

    logic [DISP_DATA_W-1:0]  data_arr [NUM_SRC];
    logic [SRC_W-1:0]        lo_idx, hi_idx, win, sel_idx;
    logic                    found_hi, any_req, owner_req, others_req;
    logic [DISP_DATA_W-1:0]  sel_data;
    logic [DW_W-1:0]         dwell_inc;

    function automatic logic [DW_W-1:0] sat_inc(input logic [DW_W-1:0] v);
        return (v >= DW_MAX) ? DW_MAX : v + DW_W'(1);
    endfunction

    disp_scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .system_clock (system_clock),
        .cpu_rst_n    (cpu_rst_n),
        .scan_ce      (scan_ce)
    );

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            data_arr[i] = src_data[i*DISP_DATA_W +: DISP_DATA_W];
        end
    end

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        found_hi = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_req[i]) begin
                lo_idx = SRC_W'(i);
                if (SRC_W'(i) >= rr_q) begin
                    hi_idx   = SRC_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        win = found_hi ? hi_idx : lo_idx;
    end

    always_comb begin
        any_req    = |src_req;
        owner_req  = src_req[active_q];
        others_req = |(src_req & ~grant_q);
        dwell_inc  = sat_inc(dwell_q);
        sel_idx    = (state_q == IDLE) ? win : active_q;
        sel_data   = data_arr[sel_idx];
`ifdef DISP_SRC_TAG_EN
        sel_data[DISP_DATA_W-1 -: 4] = 4'(sel_idx);
`endif
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        active_d = active_q;
        valid_d  = valid_q;
        seg_d    = seg_q;
        dwell_d  = dwell_q;
        rr_d     = rr_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = DWELL;
                    grant_d  = NUM_SRC'(1) << win;
                    active_d = win;
                    valid_d  = 1'b1;
                    seg_d    = sel_data;
                    dwell_d  = '0;
                    rr_d     = (win == SRC_LAST) ? '0 : win + SRC_W'(1);
                end
            end
            DWELL, HOLD: begin
                // Voluntary release wins over refresh; handover only once dwell is met.
                if (!owner_req || (state_q == HOLD && others_req)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                end else if (scan_ce) begin
                    seg_d   = sel_data;
                    dwell_d = dwell_inc;
                    if (state_q == DWELL && dwell_inc == DW_MAX) begin
                        state_d = HOLD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge system_clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
            seg_q    <= '0;
            dwell_q  <= '0;
            rr_q     <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            seg_q    <= seg_d;
            dwell_q  <= dwell_d;
            rr_q     <= rr_d;
        end
    end

    assign src_grant     = grant_q;
    assign active_src    = active_q;
    assign display_valid = valid_q;
    assign seg87         = seg_q[31:24];
    assign seg65         = seg_q[23:16];
    assign seg43         = seg_q[15:8];
    assign seg21         = seg_q[7:0];

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler with NUM_SRC=4, SCAN_DIV=4, DWELL_SCANS=3.
// A cycle-level owner/scan model built from plain integers predicts every output.
module tb_display_scheduler;

    localparam int NUM_SRC     = 4;
    localparam int SCAN_DIV    = 4;
    localparam int DWELL_SCANS = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   src_req;
    logic [31:0]  data_arr [4];
    logic [127:0] src_data;
    logic [3:0]   src_grant;
    logic [1:0]   active_src;
    logic         display_valid;
    logic         scan_ce;
    logic [7:0]   seg87, seg65, seg43, seg21;
    logic [39:0]  obs;

    int errors = 0;
    int checks = 0;

    int          m_owner;
    int          m_last;
    int          m_phase;
    int          m_dwell;
    logic [31:0] m_seg;

    assign src_data = {data_arr[3], data_arr[2], data_arr[1], data_arr[0]};
    assign obs = {src_grant, display_valid, active_src, scan_ce, seg87, seg65, seg43, seg21};

    always #5 clk = ~clk;

    display_scheduler #(
        .NUM_SRC     (NUM_SRC),
        .SCAN_DIV    (SCAN_DIV),
        .DWELL_SCANS (DWELL_SCANS)
    ) dut (
        .system_clock  (clk),
        .cpu_rst_n     (rst_n),
        .src_req       (src_req),
        .src_data      (src_data),
        .src_grant     (src_grant),
        .active_src    (active_src),
        .display_valid (display_valid),
        .scan_ce       (scan_ce),
        .seg87         (seg87),
        .seg65         (seg65),
        .seg43         (seg43),
        .seg21         (seg21)
    );

    function automatic logic [31:0] shown(input int idx);
        logic [31:0] d;
        d = data_arr[idx];
`ifdef DISP_SRC_TAG_EN
        d[31:28] = 4'(idx);
`endif
        return d;
    endfunction

    function automatic logic [39:0] expected();
        logic [3:0] g;
        logic [1:0] a;
        logic       v;
        logic       s;
        g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        a = (m_last < 0) ? 2'd0 : 2'(m_last);
        v = (m_owner >= 0);
        s = (m_phase == SCAN_DIV - 1);
        return {g, v, a, s, m_seg};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = -1;
        m_phase = 0;
        m_dwell = 0;
        m_seg   = 32'h0;
    endtask

    // One clock of the owner rules, evaluated on the inputs present during the cycle.
    task automatic model_eval();
        bit         scan;
        int         w;
        logic [3:0] own_mask;
        scan = (m_phase == SCAN_DIV - 1);
        w = 0;
        if (m_owner < 0) begin
            if (src_req != 4'b0000) begin
                for (int k = 1; k <= NUM_SRC; k++) begin
                    w = (m_last + k) % NUM_SRC;
                    if (src_req[w]) break;
                end
                m_owner = w;
                m_last  = w;
                m_seg   = shown(w);
                m_dwell = 0;
            end
        end else begin
            own_mask = 4'b0001 << m_owner;
            if (!src_req[m_owner]) begin
                m_owner = -1;
            end else if (m_dwell >= DWELL_SCANS && (src_req & ~own_mask) != 4'b0000) begin
                m_owner = -1;
            end else if (scan) begin
                m_seg = shown(m_owner);
                if (m_dwell < DWELL_SCANS) m_dwell++;
            end
        end
        m_phase = (m_phase + 1) % SCAN_DIV;
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int first_pulse;
        int pulses;
        rst_n   = 1'b0;
        src_req = 4'b0000;
        for (int s = 0; s < 4; s++) data_arr[s] = $urandom();
        @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (obs !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 40'h0);
        end
        rst_n = 1'b1;
        first_pulse = -1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (obs !== expected()) begin
                errors++;
                $display("FAIL idle_scan c=%0d: got %h expected %h", c, obs, expected());
            end
            if (scan_ce === 1'b1) begin
                pulses++;
                if (first_pulse < 0) first_pulse = c + 1;
            end
        end
        checks++;
        if (first_pulse !== 3 || pulses !== 3) begin
            errors++;
            $display("FAIL scan_period: got first=%0d count=%0d expected first=3 count=3", first_pulse, pulses);
        end
    endtask

    task automatic test_single_grant();
        data_arr[1] = 32'h12345678;
        src_req = 4'b0010;
        tick();
        checks++;
        if ({src_grant, display_valid, seg87, seg65, seg43, seg21} !== {4'b0010, 1'b1, 32'h12345678}) begin
            errors++;
            $display("FAIL first_grant: got %b/%b/%h expected 0010/1/12345678",
                     src_grant, display_valid, {seg87, seg65, seg43, seg21});
        end
        checks++;
        if (obs !== expected()) begin
            errors++;
            $display("FAIL first_grant_model: got %h expected %h", obs, expected());
        end
        data_arr[1] = 32'hCAFE0001;
        for (int i = 0; i < 8 && scan_ce !== 1'b1; i++) begin
            tick();
            checks++;
            if (obs !== expected()) begin
                errors++;
                $display("FAIL refresh_wait i=%0d: got %h expected %h", i, obs, expected());
            end
        end
        checks++;
        if (scan_ce !== 1'b1) begin
            errors++;
            $display("FAIL scan_wait_timeout: got scan_ce=%b expected 1", scan_ce);
        end
        tick();
        checks++;
        if ({seg87, seg65, seg43, seg21} !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL live_refresh: got %h expected cafe0001", {seg87, seg65, seg43, seg21});
        end
        src_req = 4'b0000;
        tick();
        checks++;
        if ({src_grant, display_valid, active_src, seg87, seg65, seg43, seg21} !== {4'b0, 1'b0, 2'd1, 32'hCAFE0001}) begin
            errors++;
            $display("FAIL voluntary_release: got %b/%b/%0d/%h expected 0000/0/1/cafe0001",
                     src_grant, display_valid, active_src, {seg87, seg65, seg43, seg21});
        end
    endtask

    task automatic test_async_reset();
        src_req = 4'b0010;
        tick();
        checks++;
        if (src_grant !== 4'b0010) begin
            errors++;
            $display("FAIL pre_reset_grant: got %b expected 0010", src_grant);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== 40'h0) begin
            errors++;
            $display("FAIL async_reset_clear: got %h expected %h", obs, 40'h0);
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        src_req = 4'b0101;
        tick();
        checks++;
        if (src_grant !== 4'b0001) begin
            errors++;
            $display("FAIL rr_restart: got %b expected 0001", src_grant);
        end
    endtask

    task automatic test_alternate();
        int prev_owner;
        int gap;
        int handovers;
        int owner;
        prev_owner = 0;
        gap = 0;
        handovers = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            checks++;
            if (obs !== expected()) begin
                errors++;
                $display("FAIL alternate c=%0d: got %h expected %h", c, obs, expected());
            end
            if (src_grant == 4'b0000) begin
                gap++;
            end else begin
                owner = $clog2(src_grant);
                if (owner != prev_owner) begin
                    handovers++;
                    checks++;
                    if (gap !== 1 || owner !== ((prev_owner == 0) ? 2 : 0)) begin
                        errors++;
                        $display("FAIL handover c=%0d: got owner=%0d gap=%0d expected owner=%0d gap=1",
                                 c, owner, gap, (prev_owner == 0) ? 2 : 0);
                    end
                    prev_owner = owner;
                end
                gap = 0;
            end
        end
        checks++;
        if (handovers < 4) begin
            errors++;
            $display("FAIL alternation_count: got %0d expected at least 4", handovers);
        end
    endtask

    task automatic test_owner_drop();
        logic [31:0] kept;
        for (int i = 0; i < 40 && src_grant !== 4'b0100; i++) tick();
        checks++;
        if (src_grant !== 4'b0100) begin
            errors++;
            $display("FAIL wait_src2_timeout: got %b expected 0100", src_grant);
        end
        for (int i = 0; i < 8 && scan_ce !== 1'b1; i++) tick();
        tick();
        kept = {seg87, seg65, seg43, seg21};
        src_req = 4'b0000;
        tick();
        checks++;
        if ({src_grant, display_valid, active_src, seg87, seg65, seg43, seg21} !== {4'b0, 1'b0, 2'd2, kept}) begin
            errors++;
            $display("FAIL owner_drop: got %b/%b/%0d/%h expected 0000/0/2/%h",
                     src_grant, display_valid, active_src, {seg87, seg65, seg43, seg21}, kept);
        end
        checks++;
        if (obs !== expected()) begin
            errors++;
            $display("FAIL owner_drop_model: got %h expected %h", obs, expected());
        end
    endtask

    task automatic test_back_to_back();
        src_req = 4'b0001;
        tick();
        checks++;
        if (src_grant !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_first: got %b expected 0001", src_grant);
        end
        src_req = 4'b0010;
        tick();
        checks++;
        if (src_grant !== 4'b0000 || display_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release_first: got %b/%b expected 0000/0", src_grant, display_valid);
        end
        tick();
        checks++;
        if (src_grant !== 4'b0010 || active_src !== 2'd1) begin
            errors++;
            $display("FAIL b2b_next_owner: got %b/%0d expected 0010/1", src_grant, active_src);
        end
        checks++;
        if (obs !== expected()) begin
            errors++;
            $display("FAIL b2b_model: got %h expected %h", obs, expected());
        end
        src_req = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        int b;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                b = $urandom_range(0, 3);
                src_req[b] = ~src_req[b];
            end
            for (int s = 0; s < 4; s++) begin
                if ($urandom_range(0, 3) == 0) data_arr[s] = $urandom();
            end
            tick();
            checks++;
            if (obs !== expected()) begin
                errors++;
                $display("FAIL random c=%0d: got %h expected %h", c, obs, expected());
            end
        end
    endtask

    task automatic test_tag();
`ifdef DISP_SRC_TAG_EN
        src_req = 4'b0000;
        tick();
        tick();
        data_arr[3] = 32'hFFFFFFFF;
        src_req = 4'b1000;
        tick();
        checks++;
        if (seg87 !== 8'h3F) begin
            errors++;
            $display("FAIL src_tag: got %h expected 3f", seg87);
        end
        src_req = 4'b0000;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_async_reset();
        test_alternate();
        test_owner_drop();
        test_back_to_back();
        test_random();
        test_tag();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
